// File: rtl/fire_pkg.sv
// Shared fire/squeeze pixel-path definitions: pixel type, output-size math, tap order, streamer states.
// The streamer's optional window counter is enabled by STREAMER_PERF_CNT_EN.
package fire_pkg;
    localparam int PIX_W = 16;
    typedef logic [PIX_W-1:0] pix_t;

    // Tap walk inside a window, fastest axis first; weight-ROM address generators follow the same order.
    typedef enum logic [1:0] {
        TAP_AXIS_KX = 2'd0,
        TAP_AXIS_KY = 2'd1,
        TAP_AXIS_CH = 2'd2
    } tap_axis_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP,
        ST_DONE
    } strm_state_e;

    function automatic int out_dim(input int in_dim, input int k, input int s, input int p);
        return (in_dim + 2 * p - k) / s + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fire_window_streamer_if.sv
// Streamer bus: start/busy/done control, IFM RAM read port and serial pixel output.
// win_count is present only when STREAMER_PERF_CNT_EN is defined.
interface fire_window_streamer_if #(
    parameter int ADDR_W = 20,
    parameter int WIDTH  = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [WIDTH-1:0]  ram_rdata;
    logic [WIDTH-1:0]  pix;
    logic              pix_valid;
    logic              win_last;
`ifdef STREAMER_PERF_CNT_EN
    logic [31:0]       win_count;
`endif

    modport master (
        input  start, ram_rdata,
        output busy, done, ram_addr, ram_rd_en, pix, pix_valid, win_last
`ifdef STREAMER_PERF_CNT_EN
        , output win_count
`endif
    );

    modport slave (
        output start, ram_rdata,
        input  busy, done, ram_addr, ram_rd_en, pix, pix_valid, win_last
`ifdef STREAMER_PERF_CNT_EN
        , input win_count
`endif
    );
endinterface

// File: rtl/fire_addr_gen.sv
// Window tap walker: kx/ky/c/ox/oy counters giving IFM address, pad flag and last-tap/last-window flags.
// Outputs are combinational from the counters; advances only on step/win_adv, no backpressure.
module fire_addr_gen
    import fire_pkg::*;
#(
    parameter int W_IN       = 128,
    parameter int H_IN       = 128,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 2,
    parameter int PAD        = 1,
    parameter int ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              win_adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              pad_o,
    output logic              last_tap_o,
    output logic              last_win_o
);
    localparam int W_OUT = out_dim(W_IN, KERNEL_DIM, STRIDE, PAD);
    localparam int H_OUT = out_dim(H_IN, KERNEL_DIM, STRIDE, PAD);
    localparam int KW    = cnt_w(KERNEL_DIM);
    localparam int CW    = cnt_w(CHIN);
    localparam int XW    = cnt_w(W_OUT);
    localparam int YW    = cnt_w(H_OUT);

    logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
    logic [CW-1:0]     c_q, c_d;
    logic [XW-1:0]     ox_q, ox_d;
    logic [YW-1:0]     oy_q, oy_d;
    logic              kx_end, ky_end, c_end, ox_end, oy_end;
    int                iy, ix;
    logic [ADDR_W-1:0] iy_u, ix_u;

    assign kx_end     = (kx_q == KW'(KERNEL_DIM - 1));
    assign ky_end     = (ky_q == KW'(KERNEL_DIM - 1));
    assign c_end      = (c_q == CW'(CHIN - 1));
    assign ox_end     = (ox_q == XW'(W_OUT - 1));
    assign oy_end     = (oy_q == YW'(H_OUT - 1));
    assign last_tap_o = kx_end && ky_end && c_end;
    assign last_win_o = ox_end && oy_end;

    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        c_d  = c_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (clear_i) begin
            kx_d = '0;
            ky_d = '0;
            c_d  = '0;
            ox_d = '0;
            oy_d = '0;
        end else if (step_i) begin
            kx_d = kx_end ? '0 : kx_q + KW'(1);
            if (kx_end) begin
                ky_d = ky_end ? '0 : ky_q + KW'(1);
                if (ky_end) c_d = c_end ? '0 : c_q + CW'(1);
            end
        end else if (win_adv_i) begin
            ox_d = ox_end ? '0 : ox_q + XW'(1);
            if (ox_end) oy_d = oy_end ? '0 : oy_q + YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kx_q <= '0;
            ky_q <= '0;
            c_q  <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            c_q  <= c_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    // Signed tap coordinates are range-checked first so only in-map values reach the multiply.
    always_comb begin
        iy     = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
        ix     = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
        pad_o  = (iy < 0) || (iy >= H_IN) || (ix < 0) || (ix >= W_IN);
        iy_u   = pad_o ? '0 : ADDR_W'(iy);
        ix_u   = pad_o ? '0 : ADDR_W'(ix);
        addr_o = (ADDR_W'(c_q) * ADDR_W'(H_IN) + iy_u) * ADDR_W'(W_IN) + ix_u;
    end
endmodule

// File: rtl/fire_window_streamer.sv
// Streams each KxKxCHIN IFM window as one zero-padded pixel per cycle plus one bubble; start->pix_valid 2 cycles.
// No backpressure: the MAC consumer runs in lock-step; optional win_count via STREAMER_PERF_CNT_EN.
module fire_window_streamer
    import fire_pkg::*;
#(
    parameter int W_IN       = 128,
    parameter int H_IN       = 128,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 2,
    parameter int PAD        = 1,
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = $clog2(W_IN * H_IN * CHIN)
) (
    input logic                    clk,
    input logic                    rst,
    fire_window_streamer_if.master bus
);
    strm_state_e       state_q, state_d;
    logic              accept, issue, win_adv, rd_en;
    logic              pad, last_tap, last_win;
    logic [ADDR_W-1:0] tap_addr;
    logic              vld_q, pad_q, last_q, busy_q, busy_d, done_q;

    fire_addr_gen #(
        .W_IN(W_IN), .H_IN(H_IN), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM),
        .STRIDE(STRIDE), .PAD(PAD), .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk(clk), .rst(rst),
        .clear_i(accept), .step_i(issue), .win_adv_i(win_adv),
        .addr_o(tap_addr), .pad_o(pad), .last_tap_o(last_tap), .last_win_o(last_win)
    );

    // done_q stretches the DONE phase into the output stage, so a start seen alongside the pulse is dropped.
    assign accept  = (state_q == ST_IDLE) && bus.start && !done_q;
    assign issue   = (state_q == ST_STREAM);
    assign win_adv = (state_q == ST_GAP);
    assign rd_en   = issue && !pad;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_STREAM;
            ST_STREAM: if (last_tap) state_d = ST_GAP;
            ST_GAP:    state_d = last_win ? ST_DONE : ST_STREAM;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (accept) busy_d = 1'b1;
        else if (state_q == ST_DONE) busy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= issue;
            pad_q   <= pad;
            last_q  <= issue && last_tap;
            busy_q  <= busy_d;
            done_q  <= (state_q == ST_DONE);
        end
    end

    assign bus.ram_rd_en = rd_en;
    assign bus.ram_addr  = rd_en ? tap_addr : '0;
    assign bus.pix       = (vld_q && !pad_q) ? bus.ram_rdata : '0;
    assign bus.pix_valid = vld_q;
    assign bus.win_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef STREAMER_PERF_CNT_EN
    logic [31:0] win_cnt_q, win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (accept) win_cnt_d = '0;
        else if (last_q) win_cnt_d = win_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) win_cnt_q <= '0;
        else      win_cnt_q <= win_cnt_d;
    end

    assign bus.win_count = win_cnt_q;
`endif
endmodule

// File: doc/fire_window_streamer.md
Name: fire_window_streamer

Overview:
- Transmit side of the serial pixel interface used by the fire/squeeze conv cores.
- Reads a CHIN-channel input feature map from a synchronous IFM RAM and emits, for every output position, one KERNEL_DIM×KERNEL_DIM×CHIN window as a serial pixel stream, one pixel per cycle.
- Zero padding and stride are handled here, so the downstream MAC array (weight ROM address 0..CHIN*K*K-1, then one clear cycle) consumes pixels in lock-step with its weights.

Parameters:
- W_IN, 128, input width in pixels
- H_IN, 128, input height in pixels
- CHIN, 64, input channels
- KERNEL_DIM, 3, window side K
- STRIDE, 2, window step in x and y
- PAD, 1, zero border on each side
- WIDTH, 16, pixel width (Q8.8)
- ADDR_W, $clog2(W_IN*H_IN*CHIN), IFM RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to stream the whole map
- ram_addr  out  ADDR_W  IFM RAM address; layout (c*H_IN+y)*W_IN+x
- ram_rd_en  out  1  read strobe; low for padded taps
- ram_rdata  in  WIDTH  RAM data, valid one cycle after ram_rd_en
- pix  out  WIDTH  streamed pixel
- pix_valid  out  1  pix carries a window tap
- win_last  out  1  high with the final tap of each window
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after the final window

Behaviour:
- Reset (async, rst low):
  - FSM→IDLE; all counters 0.
  - ram_addr=0, ram_rd_en=0, pix=0, pix_valid=0, win_last=0, busy=0, done=0.
- Output dimensions: H_OUT=(H_IN+2*PAD-K)/STRIDE+1, W_OUT likewise; defaults give 64×64.
- Tap order inside a window:
  - index k=c*K*K+ky*K+kx, with kx fastest, then ky, then c.
  - Window order: ox fastest, then oy.
- Tap coordinates: iy=oy*STRIDE+ky-PAD, ix=ox*STRIDE+kx-PAD (signed).
- Padded tap (iy or ix outside the map): ram_rd_en=0 and pix=0 one cycle later.
- FSM states IDLE, STREAM, GAP, DONE:
  - IDLE: start=1 → STREAM next cycle, busy=1. start is ignored in every other state.
  - STREAM: one tap address issued per cycle for CHIN*K*K cycles. After the last tap → GAP.
  - GAP: one cycle, no address issued. If this was the last window → DONE, otherwise → STREAM with ox/oy advanced.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Two-stage pipeline, stage 0 = address/pad, stage 1 = data mux:
  - pix, pix_valid and win_last lag the address by exactly 1 cycle.
  - Total start→first pix_valid latency is 2 cycles.
- Window period on pix_valid is CHIN*K*K+1 cycles, with one invalid bubble (pix=0) matching the consumer's clear/sample cycle.
- Full run with defaults: 4096 windows × 577 cycles.
- Address arithmetic: full-width unsigned product; no wrap inside a valid run. The bound check is done before the multiply.
- Reset mid-run: immediate abort to IDLE, no done pulse; a new start restarts from window (0,0).
- start coinciding with done (DONE state): ignored.

Optional Feature:
- Macro STREAMER_PERF_CNT_EN.
- Defined: adds output port win_count [31:0], the number of completed windows.
  - Increments on each win_last.
  - Cleared on reset and on accepted start.
  - Holds its value after done.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package fire_pkg:
  - typedef pix_t logic [WIDTH-1:0].
  - Function out_dim(in, k, s, p).
  - Tap-order enum/constants used by this block and the weight-ROM address generators.
- Sub-module fire_addr_gen: holds the kx/ky/c/ox/oy counters and produces ram_addr, the pad flag and the last-tap/last-window flags.
- Top level holds the FSM and the output pipeline stage.

Test Plan (small config W_IN=H_IN=4, CHIN=2, K=3, STRIDE=1, PAD=1, RAM[a]=a+100):
- Reset then idle: all outputs 0 for 20 cycles; start pulse → busy=1 next cycle, first pix_valid 2 cycles after start.
- Window (0,0), channel 0: pix = 0,0,0,0,100,101,0,104,105; channel 1 = same pattern +16; win_last on the 18th tap; pix_valid=0 for the bubble.
- Full run: 16 windows, pix_valid high 288 cycles total; done pulses once, 16*19+2 cycles after start; busy drops with done.
- Padding: ram_rd_en never high for out-of-range taps; the maximum address issued is 31.
- Re-assert start during busy and coincident with done → ignored; run length unchanged.
- rst low during window 5 → outputs 0 asynchronously, no done; next start replays window (0,0) exactly; with STREAMER_PERF_CNT_EN, win_count=16 after a clean run.
